// File: rtl/soc_ram_pkg.sv
// soc_ram_pkg: shared types, read-during-write selectors and lane-merge helper for soc_ram_spx
package soc_ram_pkg;

  typedef enum logic {RAM_CLEAR, RAM_READY} ram_state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  // widest word the helper handles; callers zero-extend and truncate around it
  localparam int MAX_NB = 32;
  localparam int MAX_DW = 8 * MAX_NB;

  // replace every byte whose active-low lane enable is 0 with the new byte
  function automatic logic [MAX_DW-1:0] byte_merge(
    input logic [MAX_DW-1:0] old_w,
    input logic [MAX_DW-1:0] new_w,
    input logic [MAX_NB-1:0] wen
  );
    logic [MAX_DW-1:0] m;
    m = old_w;
    for (int i = 0; i < MAX_NB; i++)
      if (!wen[i]) m[8*i +: 8] = new_w[8*i +: 8];
    return m;
  endfunction

endpackage

// File: rtl/soc_ram_spx_array.sv
// soc_ram_spx_array: word storage with per-lane write enables and an asynchronous word read
module soc_ram_spx_array
  import soc_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 128,
  parameter int IW         = 7
) (
  input  logic                    clk,
  input  logic [DATA_WIDTH/8-1:0] we,
  input  logic [IW-1:0]           addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  // write only the lanes whose enable is set
  always_ff @(posedge clk)
    for (int i = 0; i < NB; i++)
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];

endmodule

// File: rtl/soc_ram_spx.sv
// soc_ram_spx: single-port byte-lane RAM with post-reset clear, range check and optional output register
module soc_ram_spx
  import soc_ram_pkg::*;
#(
  parameter int                    DATA_WIDTH = 16,
  parameter int                    ADDR_MSB   = 6,
  parameter int                    MEM_SIZE   = 256,
  parameter int                    OUT_REG    = 0,
  parameter int                    RDW_MODE   = RDW_READ_FIRST,
  parameter int                    CLEAR_EN   = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VAL  = '0
) (
  input  logic                    soc_ram_clk,
  input  logic                    soc_ram_rst,
  input  logic [ADDR_MSB:0]       soc_ram_addr,
  input  logic                    soc_ram_cen,
  input  logic [DATA_WIDTH/8-1:0] soc_ram_wen,
  input  logic [DATA_WIDTH-1:0]   soc_ram_din,
  output logic [DATA_WIDTH-1:0]   soc_ram_dout,
  output logic                    soc_ram_dout_vld,
  output logic                    soc_ram_err,
  output logic                    soc_ram_busy
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = MEM_SIZE / NB;
  localparam int AW    = ADDR_MSB + 1;
  localparam int IW    = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
  localparam logic [IW-1:0] LAST  = IW'(DEPTH - 1);

  ram_state_t            state;
  logic [IW-1:0]         cnt;
  logic                  acc, in_rng, clearing;
  logic [NB-1:0]         we;
  logic [IW-1:0]         mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata, old_w, merged, rd;
  logic [DATA_WIDTH-1:0] d1;
  logic                  v1, e1;

  assign in_rng    = {1'b0, soc_ram_addr} < DEPTH_W;
  assign acc       = state == RAM_READY && !soc_ram_cen;
  assign clearing  = state == RAM_CLEAR && !soc_ram_rst;
  assign mem_addr  = clearing ? cnt : soc_ram_addr[IW-1:0];
  assign mem_wdata = clearing ? CLEAR_VAL : soc_ram_din;
  assign merged    = DATA_WIDTH'(byte_merge(MAX_DW'(old_w), MAX_DW'(soc_ram_din), MAX_NB'(soc_ram_wen)));
  assign rd        = !in_rng ? '0 : RDW_MODE == RDW_WRITE_FIRST ? merged : old_w;

  // lane enables: all lanes while clearing, active-low wen for in-range accesses, nothing otherwise
  always_comb begin
    we = '0;
    we = clearing ? {NB{1'b1}} : (acc && in_rng && !soc_ram_rst) ? ~soc_ram_wen : '0;
  end

  soc_ram_spx_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .IW        (IW)
  ) u_array (
    .clk  (soc_ram_clk),
    .we   (we),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(old_w)
  );

  // clear engine: walk every word once after reset, then stay ready until the next reset
  always_ff @(posedge soc_ram_clk)
    if (soc_ram_rst) begin
      state        <= CLEAR_EN != 0 ? RAM_CLEAR : RAM_READY;
      soc_ram_busy <= CLEAR_EN != 0;
      cnt          <= '0;
    end else if (state == RAM_CLEAR) begin
      cnt          <= cnt + 1'b1;
      state        <= cnt == LAST ? RAM_READY : RAM_CLEAR;
      soc_ram_busy <= cnt != LAST;
    end

  // first read stage: capture the returned word and its strobes for every accepted access
  always_ff @(posedge soc_ram_clk)
    if (soc_ram_rst) begin
      d1 <= '0;
      v1 <= 1'b0;
      e1 <= 1'b0;
    end else begin
      v1 <= acc;
      e1 <= acc && !in_rng;
      if (acc) d1 <= rd;
    end

  if (OUT_REG != 0) begin : g_oreg
    // optional second stage: one more cycle of latency, dout still holds between accesses
    always_ff @(posedge soc_ram_clk)
      if (soc_ram_rst) begin
        soc_ram_dout     <= '0;
        soc_ram_dout_vld <= 1'b0;
        soc_ram_err      <= 1'b0;
      end else begin
        soc_ram_dout_vld <= v1;
        soc_ram_err      <= e1;
        if (v1) soc_ram_dout <= d1;
      end
  end else begin : g_direct
    assign soc_ram_dout     = d1;
    assign soc_ram_dout_vld = v1;
    assign soc_ram_err      = e1;
  end

endmodule
